// File: rtl/psg_multi_pkg.sv
// Shared constants, types and helpers for the multi-channel PSG.
package psg_multi_pkg;

  // Per-channel register offsets (addr[1:0] when addr[AW-1] = 0)
  localparam logic [1:0] REG_PER_LO = 2'd0;
  localparam logic [1:0] REG_PER_HI = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_PAN    = 2'd3;

  // Global register offsets (addr[1:0] when addr[AW-1] = 1)
  localparam logic [1:0] GREG_NOISE  = 2'd0;
  localparam logic [1:0] GREG_ENV_LO = 2'd1;
  localparam logic [1:0] GREG_ENV_HI = 2'd2;
  localparam logic [1:0] GREG_SHAPE  = 2'd3;

  // Envelope shape bit positions
  localparam int SHAPE_HOLD = 0;
  localparam int SHAPE_ALT  = 1;
  localparam int SHAPE_ATT  = 2;
  localparam int SHAPE_CONT = 3;

  // Noise LFSR x^17 + x^14 + 1, shifting right; feedback enters at the MSB
  localparam int          LFSR_W      = 17;
  localparam int          LFSR_TAP_LO = 0;
  localparam int          LFSR_TAP_HI = 3;
  localparam logic [16:0] LFSR_SEED   = 17'h1;

  // Channel control register layout
  typedef struct packed {
    logic       noise_en;
    logic       tone_en;
    logic       use_env;
    logic [3:0] vol;
  } ch_ctrl_t;

  // Width of an unsaturated stereo sum of nch channels
  function automatic int sw_bits(int nch, int dac_bits);
    return dac_bits + $clog2(nch) + 1;
  endfunction

  // Log-to-linear table entry: 1.5 dB per step below full scale, entry 0 silent
  function automatic int exp_entry(int idx, int dac_bits);
    real full_scale;
    real gain;
    if (idx <= 0) return 0;
    full_scale = real'((1 << dac_bits) - 1);
    gain = 10.0 ** (-1.5 * real'(31 - idx) / 20.0);
    return $rtoi(full_scale * gain + 0.5);
  endfunction

endpackage

// File: rtl/psg_exp_lut.sv
// 32-entry exponential amplitude ROM with a registered, enable-qualified read.
module psg_exp_lut
  import psg_multi_pkg::*;
#(
  parameter int DAC_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic [4:0]          log_i,
  output logic [DAC_BITS-1:0] lin_o
);

  logic [DAC_BITS-1:0] rom [32];
  logic [DAC_BITS-1:0] lin_q;

  for (genvar gi = 0; gi < 32; gi++) begin : g_rom
    assign rom[gi] = DAC_BITS'(exp_entry(gi, DAC_BITS));
  end

  // Registered table read, advancing only on the PSG clock enable
  always_ff @(posedge clk) begin
    if (rst) begin
      lin_q <= '0;
    end else if (en_i) begin
      lin_q <= rom[log_i];
    end
  end

  assign lin_o = lin_q;

endmodule

// File: rtl/psg_multi.sv
// NCH-channel square/noise/envelope sound generator with a time-multiplexed
// exponential DAC table and registered stereo mix.
module psg_multi
  import psg_multi_pkg::*;
#(
  parameter  int NCH      = 6,
  parameter  int DAC_BITS = 8,
  localparam int SW       = sw_bits(NCH, DAC_BITS),
  localparam int AW       = $clog2(NCH) + 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          ack,
  output logic [SW-1:0] left,
  output logic [SW-1:0] right,
  output logic          sample_valid
);

  localparam int CHW = AW - 2;             // channel field width incl. spare bit
  localparam int IW  = $clog2(NCH + 1);    // sequencer index width

  // Register file
  logic [11:0] period_q [NCH];
  ch_ctrl_t    ctrl_q   [NCH];
  logic [1:0]  pan_q    [NCH];
  logic [4:0]  nper_q;
  logic [15:0] eper_q;
  logic [3:0]  shape_q;
  logic        env_restart_q;

  // Bus decode
  logic           is_glob;
  logic [CHW-1:0] ch_sel;
  logic           ch_ok;
  logic [1:0]     reg_sel;
  logic           wr;
  logic [7:0]     rd_val;
  logic [7:0]     rdata_q;
  logic           ack_q;

  // Prescaler, noise, envelope
  logic [7:0]        pre_q;
  logic              cen16;
  logic              cen256;
  logic [4:0]        ndiv_q;
  logic [4:0]        nlimit;
  logic [LFSR_W-1:0] lfsr_q;
  logic              noise_bit;
  logic [15:0]       ediv_q;
  logic [4:0]        env_lvl_q;
  logic              env_up_q;
  logic              env_hold_q;
  logic              env_at_end;

  // Channels and mixer
  logic [4:0]          log_w [NCH];
  logic [IW-1:0]       idx_q;
  logic [4:0]          log_sel;
  logic [1:0]          pan_sel;
  logic [1:0]          pan_pipe_q;
  logic [DAC_BITS-1:0] lin_w;
  logic [SW-1:0]       add_l;
  logic [SW-1:0]       add_r;
  logic [SW-1:0]       acc_l_q;
  logic [SW-1:0]       acc_r_q;
  logic [SW-1:0]       left_q;
  logic [SW-1:0]       right_q;
  logic                sv_q;

  assign is_glob = addr[AW-1];
  assign ch_sel  = addr[AW-2:2];
  assign ch_ok   = int'(ch_sel) < NCH;
  assign reg_sel = addr[1:0];
  assign wr      = cs & we;

  // Register writes; a shape write arms an envelope restart for the next clk_en
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        period_q[i] <= '0;
        ctrl_q[i]   <= '0;
        pan_q[i]    <= '0;
      end
      nper_q        <= '0;
      eper_q        <= '0;
      shape_q       <= '0;
      env_restart_q <= 1'b0;
    end else begin
      if (clk_en) env_restart_q <= 1'b0;
      if (wr) begin
        if (is_glob) begin
          case (reg_sel)
            GREG_NOISE:  nper_q        <= wdata[4:0];
            GREG_ENV_LO: eper_q[7:0]   <= wdata;
            GREG_ENV_HI: eper_q[15:8]  <= wdata;
            GREG_SHAPE: begin
              shape_q       <= wdata[3:0];
              env_restart_q <= 1'b1;
            end
          endcase
        end else if (ch_ok) begin
          case (reg_sel)
            REG_PER_LO: period_q[ch_sel[CHW-2:0]][7:0]  <= wdata;
            REG_PER_HI: period_q[ch_sel[CHW-2:0]][11:8] <= wdata[3:0];
            REG_CTRL:   ctrl_q[ch_sel[CHW-2:0]]         <= wdata[6:0];
            REG_PAN:    pan_q[ch_sel[CHW-2:0]]          <= wdata[1:0];
          endcase
        end
      end
    end
  end

  // Read mux, masked to defined bits; unimplemented channels read zero
  always_comb begin
    rd_val = 8'h00;
    if (is_glob) begin
      case (reg_sel)
        GREG_NOISE:  rd_val = {3'b000, nper_q};
        GREG_ENV_LO: rd_val = eper_q[7:0];
        GREG_ENV_HI: rd_val = eper_q[15:8];
        GREG_SHAPE:  rd_val = {4'h0, shape_q};
      endcase
    end else if (ch_ok) begin
      case (reg_sel)
        REG_PER_LO: rd_val = period_q[ch_sel[CHW-2:0]][7:0];
        REG_PER_HI: rd_val = {4'h0, period_q[ch_sel[CHW-2:0]][11:8]};
        REG_CTRL:   rd_val = {1'b0, ctrl_q[ch_sel[CHW-2:0]]};
        REG_PAN:    rd_val = {6'h00, pan_q[ch_sel[CHW-2:0]]};
      endcase
    end
  end

  // Bus response: acknowledge every selected cycle, latch read data
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= cs;
      if (cs && !we) rdata_q <= rd_val;
    end
  end

  assign ack   = ack_q;
  assign rdata = rdata_q;

  // Free-running clk_en prescaler for the tone/noise and envelope time bases
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else if (clk_en) begin
      pre_q <= pre_q + 8'd1;
    end
  end

  assign cen16  = clk_en & (pre_q[3:0] == 4'hF);
  assign cen256 = clk_en & (pre_q == 8'hFF);

  // Noise divider and LFSR; period 0 behaves as 1
  assign nlimit = (nper_q == 5'd0) ? 5'd0 : nper_q - 5'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ndiv_q <= '0;
      lfsr_q <= LFSR_SEED;
    end else if (cen16) begin
      if (ndiv_q >= nlimit) begin
        ndiv_q <= '0;
        lfsr_q <= {lfsr_q[LFSR_TAP_LO] ^ lfsr_q[LFSR_TAP_HI], lfsr_q[LFSR_W-1:1]};
      end else begin
        ndiv_q <= ndiv_q + 5'd1;
      end
    end
  end

  assign noise_bit  = lfsr_q[0];
  assign env_at_end = env_up_q ? (env_lvl_q == 5'd31) : (env_lvl_q == 5'd0);

  // Envelope: restart wins over a coincident step; period 0 freezes the level
  always_ff @(posedge clk) begin
    if (rst) begin
      ediv_q     <= '0;
      env_lvl_q  <= '0;
      env_up_q   <= 1'b0;
      env_hold_q <= 1'b0;
    end else if (clk_en && env_restart_q) begin
      ediv_q     <= '0;
      env_lvl_q  <= shape_q[SHAPE_ATT] ? 5'd0 : 5'd31;
      env_up_q   <= shape_q[SHAPE_ATT];
      env_hold_q <= 1'b0;
    end else if (cen256 && eper_q != 16'd0) begin
      if (ediv_q >= eper_q - 16'd1) begin
        ediv_q <= '0;
        if (!env_hold_q) begin
          if (!env_at_end) begin
            env_lvl_q <= env_up_q ? env_lvl_q + 5'd1 : env_lvl_q - 5'd1;
          end else if (!shape_q[SHAPE_CONT]) begin
            env_lvl_q  <= 5'd0;
            env_hold_q <= 1'b1;
          end else if (shape_q[SHAPE_HOLD]) begin
            env_lvl_q  <= shape_q[SHAPE_ALT] ? ~env_lvl_q : env_lvl_q;
            env_hold_q <= 1'b1;
          end else if (shape_q[SHAPE_ALT]) begin
            env_up_q <= ~env_up_q;
          end else begin
            env_lvl_q <= env_up_q ? 5'd0 : 5'd31;
          end
        end
      end else begin
        ediv_q <= ediv_q + 16'd1;
      end
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [11:0] cnt_q;
    logic        sq_q;
    logic [11:0] limit;
    logic        gate;

    assign limit = (period_q[gi] == 12'd0) ? 12'd0 : period_q[gi] - 12'd1;

    // Tone counter; the >= compare lets a shortened period wrap immediately
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        sq_q  <= 1'b0;
      end else if (cen16) begin
        if (cnt_q >= limit) begin
          cnt_q <= '0;
          sq_q  <= ~sq_q;
        end else begin
          cnt_q <= cnt_q + 12'd1;
        end
      end
    end

    assign gate = (sq_q | ~ctrl_q[gi].tone_en) & (noise_bit | ~ctrl_q[gi].noise_en);
    assign log_w[gi] = !gate              ? 5'd0 :
                       ctrl_q[gi].use_env ? env_lvl_q :
                                            {ctrl_q[gi].vol, ctrl_q[gi].vol[3]};
  end

  // Sequencer selects one channel per clk_en; index NCH is the output slot
  always_comb begin
    log_sel = 5'd0;
    pan_sel = 2'b00;
    if (int'(idx_q) < NCH) begin
      log_sel = log_w[idx_q[CHW-2:0]];
      pan_sel = pan_q[idx_q[CHW-2:0]];
    end
  end

  psg_exp_lut #(
    .DAC_BITS (DAC_BITS)
  ) u_lut (
    .clk   (clk),
    .rst   (rst),
    .en_i  (clk_en),
    .log_i (log_sel),
    .lin_o (lin_w)
  );

  assign add_l = pan_pipe_q[0] ? {{(SW - DAC_BITS){1'b0}}, lin_w} : '0;
  assign add_r = pan_pipe_q[1] ? {{(SW - DAC_BITS){1'b0}}, lin_w} : '0;

  // Accumulate the previous slot's linear level; publish and clear after the last
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      pan_pipe_q <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      left_q     <= '0;
      right_q    <= '0;
      sv_q       <= 1'b0;
    end else begin
      sv_q <= 1'b0;
      if (clk_en) begin
        pan_pipe_q <= pan_sel;
        if (int'(idx_q) == NCH) begin
          left_q  <= acc_l_q + add_l;
          right_q <= acc_r_q + add_r;
          sv_q    <= 1'b1;
          acc_l_q <= '0;
          acc_r_q <= '0;
          idx_q   <= '0;
        end else begin
          if (idx_q != '0) begin
            acc_l_q <= acc_l_q + add_l;
            acc_r_q <= acc_r_q + add_r;
          end
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign left         = left_q;
  assign right        = right_q;
  assign sample_valid = sv_q;

endmodule

// File: doc/psg_multi.md
# psg_multi

Parametrised programmable sound generator that replaces the fixed three-channel PSG. NCH square-wave tone channels share one noise LFSR and one envelope generator, and each channel has its own left/right pan enables. A single exponential DAC lookup is time-multiplexed across the channels, producing registered stereo sums with a one-cycle sample strobe. It sits on the audio peripheral bus; its left/right outputs feed the audio DAC or I2S serializer.

## Interface
- NCH, 6: number of tone channels, 2..16.
- DAC_BITS, 8: linear amplitude width per channel.
- SW = DAC_BITS + $clog2(NCH) + 1: stereo sum width (derived, not overridable).
- AW = $clog2(NCH) + 3: bus address width (derived).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  PSG master clock enable; every internal action is qualified by it, except bus accesses.
- cs  in  1  bus select.
- we  in  1  write strobe, valid while cs is high.
- addr  in  AW  register address.
- wdata  in  8  write data.
- rdata  out  8  read data, registered.
- ack  out  1  one-cycle acknowledge, the cycle after cs is sampled high.
- left  out  SW  left mix.
- right  out  SW  right mix.
- sample_valid  out  1  one clk pulse when left/right update.

## Operation
- Register map, channel n (addr[AW-1]=0, n=addr[AW-2:2]):
  - reg0: period[7:0].
  - reg1: period[11:8] in bits [3:0].
  - reg2: ctrl; [3:0] vol, [4] use_env, [5] tone_en, [6] noise_en.
  - reg3: pan; [0] L, [1] R.
- Global registers (addr[AW-1]=1, addr[1:0]):
  - 0: noise period [4:0].
  - 1: env period[7:0].
  - 2: env period[15:8].
  - 3: env shape [3:0] = CONT, ATT, ALT, HOLD.
- Channel indices ≥ NCH read as 0 and ignore writes.
- Reads return each register masked to its defined bits.
- Prescaler: cen16 every 16th clk_en; cen256 every 256th clk_en.
- Tone: 12-bit counter per channel, increments on cen16. When count ≥ period-1, the counter clears and the square bit toggles. Period 0 behaves as 1.
- Noise: 5-bit divider on cen16; on wrap, a 17-bit LFSR (x^17+x^14+1) shifts. Noise bit = LFSR[0]. Period 0 behaves as 1.
- Envelope:
  - 16-bit divider on cen256 issues a step.
  - Level is 5 bits, 0..31, rising when ATT=1, otherwise falling.
  - At the end of a ramp: CONT=0 → level 0, hold. HOLD=1 → hold at the end value, inverted if ALT=1. ALT=1 alone → reverse direction. Otherwise → wrap.
  - Envelope period 0 freezes the level.
- Channel gate = (square | ~tone_en) & (noise | ~noise_en). Log level = gate ? (use_env ? env : {vol, vol[3]}) : 0.
- Mixer sequencer, one step per clk_en:
  - Index k = 0..NCH-1 presents channel k's log level to the exp table.
  - lin arrives one clk_en later and is added to accL if pan.L is set, and to accR if pan.R is set.
  - After step NCH: left ← accL, right ← accR, sample_valid = 1, both accumulators clear.
  - One output frame every NCH+1 clk_en.

## Timing
- Reset values:
  - rdata, ack, left, right, sample_valid = 0.
  - All registers 0.
  - LFSR = 17'h1.
  - All counters, square bits, sequencer index and envelope level 0.
- Bus: ack and rdata are valid one clk after the cs cycle. A write takes effect on that edge. Back-to-back accesses are allowed every cycle.
- A period written mid-count does not reset the counter. The ≥ compare forces a wrap on the next cen16 if count already exceeds the new period.
- A write to the env shape restarts the envelope (level 31 if ATT=0, else 0, divider cleared) on the following clk_en. Restart beats a simultaneous envelope step.
- Stereo sums use unsigned arithmetic. Maximum is NCH·(2^DAC_BITS−1), which fits SW bits; no saturation.
- rst asserted mid-frame discards the partial sums; no sample_valid is emitted for that frame.
- clk_en low freezes all audio state; the bus stays live.

## Structure
- Package psg_multi_pkg holds: the register offsets, the shape bit positions, the LFSR taps/seed, and the function computing SW.
- Sub-module psg_exp_lut: 32-entry log→linear ROM (≈1.5 dB steps, entry 0 = 0, entry 31 = 2^DAC_BITS−1), registered output.
- Tone counters are a generate loop over NCH.

## Test plan
- Reset, then read every address → rdata 0 and ack pulses; after NCH+1 clk_en, left=right=0 with sample_valid.
- Channel 0: period 1, vol 15, tone_en, pan L only; other channels silent → left alternates 2^DAC_BITS−1 and 0 every 16 clk_en frames; right stays 0.
- NCH=6, all channels: tone_en=0, noise_en=0, vol 15, pan LR → left=right=6·255=1530 each frame.
- Env shape 4'hD (CONT, ATT, HOLD), period 1, use_env → level ramps 0→31 in one step per 256 clk_en, then holds at 31.
- Write the shape register in the same cycle an envelope step is due → level restarts; the step is dropped.
- rst pulsed mid-frame → no sample_valid until a full NCH+1 frame completes; all registers read 0.
